// File: rtl/alu_op_issuer.sv
// alu_op_issuer: turns a one-hot op request into registered ALU controls
// or a multdiv start pulse, and returns the result over valid/ready.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake, accepted only in IDLE
//   req_sel               one-hot op: ADD SUB AND OR SLL SRA MULT DIV
//   req_a, req_b          operands
//   req_shamt             shift amount for SLL/SRA
//   ctrl_ALUopcode        registered opcode to the ALU
//   ctrl_shiftamt         registered shift amount to the ALU
//   data_operandA/B       registered operands to ALU and multdiv
//   alu_result/overflow   ALU outputs, captured one cycle after accept
//   ctrl_MULT, ctrl_DIV   one-cycle multdiv start pulses
//   md_result/exception   multdiv outputs, captured on md_resultRDY
//   md_resultRDY          multdiv completion, honoured only in MD_WAIT
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/ovf/err      response payload, held while stalled
module alu_op_issuer #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_sel,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    output logic [4:0]  ctrl_ALUopcode,
    output logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MD_START,
        MD_WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_addsub;

    logic          one_hot;
    logic [4:0]    op_code;
    logic [4:0]    op_shamt;
    logic          op_md;
    logic          op_mul;
    logic          op_addsub;

    // x & (x-1) clears the lowest set bit; zero afterwards means <= 1 bit
    assign one_hot = (req_sel != 8'd0)
                  && ((req_sel & (req_sel - 8'd1)) == 8'd0);

    always_comb begin
        op_code   = 5'd0;
        op_shamt  = 5'd0;
        op_md     = 1'b0;
        op_mul    = 1'b0;
        op_addsub = 1'b0;
        // guarded so the unique check only sees a true one-hot select
        if (one_hot) begin
            unique case (1'b1)
                req_sel[0]: op_addsub = 1'b1;
                req_sel[1]: begin
                    op_code   = 5'd1;
                    op_addsub = 1'b1;
                end
                req_sel[2]: op_code = 5'd2;
                req_sel[3]: op_code = 5'd3;
                req_sel[4]: begin
                    op_code  = 5'd4;
                    op_shamt = req_shamt;
                end
                req_sel[5]: begin
                    op_code  = 5'd5;
                    op_shamt = req_shamt;
                end
                req_sel[6]: begin
                    op_md  = 1'b1;
                    op_mul = 1'b1;
                end
                req_sel[7]: op_md = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            is_addsub      <= 1'b0;
            req_ready      <= 1'b1;
            ctrl_ALUopcode <= 5'd0;
            ctrl_shiftamt  <= 5'd0;
            data_operandA  <= 32'd0;
            data_operandB  <= 32'd0;
            ctrl_MULT      <= 1'b0;
            ctrl_DIV       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            rsp_ovf        <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (!one_hot) begin
                            // bad select: answer with an error, touch nothing
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'd0;
                            rsp_ovf   <= 1'b0;
                            rsp_err   <= 1'b1;
                        end else begin
                            data_operandA  <= req_a;
                            data_operandB  <= req_b;
                            ctrl_ALUopcode <= op_code;
                            ctrl_shiftamt  <= op_shamt;
                            is_addsub      <= op_addsub;
                            if (op_md) begin
                                ctrl_MULT <= op_mul;
                                ctrl_DIV  <= !op_mul;
                                state     <= MD_START;
                            end else begin
                                state <= EXEC;
                            end
                        end
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_ovf   <= is_addsub & alu_overflow;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                MD_START: begin
                    ctrl_MULT <= 1'b0;
                    ctrl_DIV  <= 1'b0;
                    cnt       <= '0;
                    state     <= MD_WAIT;
                end
                MD_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // completion takes priority over a coincident timeout
                    if (md_resultRDY) begin
                        rsp_data  <= md_result;
                        rsp_err   <= md_exception;
                        rsp_ovf   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data  <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_ovf   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
